// File: rtl/bitlet_normalizer.sv
// Iterative normalizer: signed aligned sum -> sign/exponent/mantissa.
// Define BITLET_NORM_ROUND_EN for round-to-nearest-even (default truncates).
module bitlet_normalizer #(
  parameter int W_ACC   = 32,
  parameter int W_EXP   = 8,
  parameter int W_MAN   = 23,
  parameter int STEP    = 4,
  parameter int ACC_OFS = W_ACC - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_ACC-1:0] in_acc,
  input  logic [W_EXP-1:0] in_emax,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [W_EXP-1:0] out_exp,
  output logic [W_MAN-1:0] out_man,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int LZW = $clog2(W_ACC) + 1;
  localparam int EW  = W_EXP + 2;
  localparam int FW  = W_ACC + W_MAN - 1;
  localparam logic signed [EW-1:0] E_MIN = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << W_EXP) - 1);

  typedef enum logic [1:0] {IDLE, SCAN, PACK, DONE} state_t;

  state_t state, state_nx;

  logic             sign;
  logic [W_ACC-1:0] mag;
  logic [W_ACC-1:0] mag_in;
  logic [W_EXP-1:0] emax;
  logic [LZW-1:0]   lz;
  logic [LZW-1:0]   lzc;
  logic             hit;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mag_in    = in_acc[W_ACC-1] ? (~in_acc + W_ACC'(1)) : in_acc;

  // Leading-zero count inside the top STEP bits; STEP when all clear.
  always_comb begin
    lzc = LZW'(STEP);
    hit = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (mag[W_ACC-1-i]) begin
        lzc = LZW'(i);
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SCAN;
      SCAN:    if (hit || mag == '0) state_nx = PACK;
      PACK:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      mag  <= '0;
      emax <= '0;
      lz   <= '0;
    end else if (accept) begin
      sign <= in_acc[W_ACC-1];
      mag  <= mag_in;
      emax <= in_emax;
      lz   <= '0;
    end else if (state == SCAN && mag != '0) begin
      mag <= mag << lzc;
      lz  <= lz + lzc;
    end
  end

  logic [FW-1:0]          frac;
  logic [W_MAN-1:0]       man_t;
  logic [W_MAN-1:0]       man_r;
  logic                   rnd;
  logic                   carry;
  logic signed [EW-1:0]   e_raw;
  logic signed [EW-1:0]   e_r;

  // Fraction below the implicit one, padded so short sums still fill man.
  always_comb begin
    frac  = {mag[W_ACC-2:0], {W_MAN{1'b0}}};
    man_t = W_MAN'(frac >> (W_ACC - 1));
`ifdef BITLET_NORM_ROUND_EN
    rnd   = frac[W_ACC-2] & ((|frac[W_ACC-3:0]) | man_t[0]);
`else
    rnd   = 1'b0;
`endif
    {carry, man_r} = {1'b0, man_t} + (W_MAN + 1)'(rnd);
    e_raw = EW'(emax) + EW'(ACC_OFS) - EW'(lz);
    e_r   = e_raw + EW'(carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_man  <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (state == PACK) begin
      if (mag == '0) begin
        out_sign <= 1'b0;
        out_exp  <= '0;
        out_man  <= '0;
        out_zero <= 1'b1;
        out_ovf  <= 1'b0;
      end else if (e_r < E_MIN) begin
        out_sign <= sign;
        out_exp  <= '0;
        out_man  <= '0;
        out_zero <= 1'b1;
        out_ovf  <= 1'b0;
      end else if (e_r > E_MAX) begin
        out_sign <= sign;
        out_exp  <= '1;
        out_man  <= '1;
        out_zero <= 1'b0;
        out_ovf  <= 1'b1;
      end else begin
        out_sign <= sign;
        out_exp  <= e_r[W_EXP-1:0];
        out_man  <= man_r;
        out_zero <= 1'b0;
        out_ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitlet_normalizer.sv
// Bench for bitlet_normalizer: directed and random operands against
// an arithmetic reference model (honours BITLET_NORM_ROUND_EN).
module tb_bitlet_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_acc = '0;
  logic [7:0]  in_emax = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_man;
  logic        out_zero;
  logic        out_ovf;

  int compared = 0;
  int mismatched = 0;

  bitlet_normalizer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_acc   (in_acc),
    .in_emax  (in_emax),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign (out_sign),
    .out_exp  (out_exp),
    .out_man  (out_man),
    .out_zero (out_zero),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Value-level model: locate MSB, take fraction bits, optionally round.
  task automatic model(input logic [31:0] a, input logic [7:0] em,
                       output logic s, output logic [7:0] ex,
                       output logic [22:0] mn, output logic z,
                       output logic o, output int lat);
    longint m, fr, q;
`ifdef BITLET_NORM_ROUND_EN
    longint rem, half;
`endif
    int p, e;
    s = 1'b0; ex = '0; mn = '0; z = 1'b0; o = 1'b0; lat = 2;
    if (a == 32'd0) begin
      z = 1'b1;
      return;
    end
    s = a[31];
    m = longint'($signed(a));
    if (m < 0) m = -m;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (((m >> i) & 1) == 1) p = i;
    lat = (31 - p) / 4 + 2;
    e = int'(em) + p;
    fr = m - (longint'(1) << p);
    if (p >= 23) begin
      q = fr >> (p - 23);
`ifdef BITLET_NORM_ROUND_EN
      rem = fr - (q << (p - 23));
      if (p >= 24) begin
        half = longint'(1) << (p - 24);
        if (rem > half || (rem == half && q[0])) q++;
      end
      if (q == (longint'(1) << 23)) begin
        q = 0;
        e++;
      end
`endif
    end else begin
      q = fr << (23 - p);
    end
    if (e < 1) begin
      z = 1'b1;
    end else if (e > 255) begin
      o = 1'b1; ex = 8'hFF; mn = 23'h7FFFFF;
    end else begin
      ex = 8'(e); mn = 23'(q);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [7:0] em,
                     input string tag, input bit hold);
    logic s, z, o;
    logic [7:0] ex;
    logic [22:0] mn;
    int lat, n;
    model(a, em, s, ex, mn, z, o, lat);
    @(negedge clk);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_acc = a; in_emax = em; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_acc = $urandom; in_emax = 8'($urandom);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".sign"}, out_sign, s);
    chk({tag, ".exp"}, out_exp, ex);
    chk({tag, ".man"}, out_man, mn);
    chk({tag, ".zero"}, out_zero, z);
    chk({tag, ".ovf"}, out_ovf, o);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        in_valid = ~in_valid; in_acc = $urandom; in_emax = 8'($urandom);
        @(posedge clk); #1;
        chk({tag, ".hold_valid"}, out_valid, 1);
        chk({tag, ".hold_ready"}, in_ready, 0);
        chk({tag, ".hold_exp"}, out_exp, ex);
        chk({tag, ".hold_man"}, out_man, mn);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drained"}, out_valid, 0);
    if (hold) chk({tag, ".no_accept"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_exp", out_exp, 0);
    chk("rst.out_zero", out_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32'h0000_0001, 8'd127, "one", 1'b0);
    run(32'hFFFF_FFFE, 8'd100, "neg2", 1'b0);
    run(32'h0000_0000, 8'd77, "zero", 1'b0);
    run(32'h01FF_FFFF, 8'd0, "round", 1'b0);
    run(32'h4000_0000, 8'd250, "ovf", 1'b0);
    run(32'h0000_0001, 8'd0, "flush", 1'b0);
    run(32'h8000_0000, 8'd10, "minneg", 1'b0);
    run(32'h7FFF_FFFF, 8'd200, "maxpos", 1'b0);
    run(32'h0001_2345, 8'd60, "hold", 1'b1);

    // Reset in the middle of a long scan.
    @(negedge clk);
    in_acc = 32'h0000_0001; in_emax = 8'd90; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_exp", out_exp, 0);
    chk("midrst.out_man", out_man, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst.no_output", out_valid, 0);
    end
    run(32'hFFF0_0000, 8'd33, "after_rst", 1'b0);

    for (int t = 0; t < 40; t++) begin
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      run(a, 8'($urandom_range(0, 255)), $sformatf("rnd%0d", t), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
